// File: rtl/qspinor_rd_seq.sv
`timescale 1ns/1ps
// qspinor_rd_seq
// ---------------------------------------------------------------------------
// Read-transaction sequencer for the QSPI NOR path. It takes 1..4 byte read
// requests at a 24-bit address and drives the byte-level QSPI I/O engine one
// byte at a time through the phases command, address, mode, dummy and data.
// It owns flash chip-select and returns the assembled data word.
//
// Optional feature: define QSPINOR_CONT_READ_EN to keep chip-select low after
// a response (HOLD state). A following request that starts exactly where the
// previous one ended then skips straight to the data phase.
//
// Ports
//   clk, rst        single clock, asynchronous active-high reset
//   req_valid/ready request handshake
//   req_addr [23:0] byte address
//   req_len  [1:0]  byte count minus 1
//   rsp_valid       one-cycle pulse with rsp_data (no backpressure)
//   rsp_data [31:0] byte k at [8k+7:8k], unrequested bytes are 0
//   io_trig         one-cycle byte start to the engine
//   io_done         one-cycle byte complete from the engine
//   io_dout  [7:0]  byte to flash
//   io_din   [7:0]  byte from flash
//   io_dir          1 = out to flash, 0 = in
//   io_wid   [1:0]  0 = 1-bit, 2 = 4-bit
//   spi_csn         flash chip select, active low
//
// Handshake: a request transfers on a clock edge where req_valid and
// req_ready are both high; req_ready depends only on the current state, never
// on req_valid. rsp_valid is a single-cycle pulse that cannot be stalled.
// ---------------------------------------------------------------------------
module qspinor_rd_seq #(
  parameter logic [7:0] READ_CMD       = 8'hEB,
  parameter logic [7:0] MODE_BYTE      = 8'h00,
  parameter int         DUMMY_BYTES    = 2,
  parameter int         CS_IDLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [1:0]  req_len,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        io_trig,
  input  logic        io_done,
  output logic [7:0]  io_dout,
  input  logic [7:0]  io_din,
  output logic        io_dir,
  output logic [1:0]  io_wid,
  output logic        spi_csn
);

  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_BYTES - 1);
  localparam logic [3:0] GAP_LAST   = 4'(CS_IDLE_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    CS_SETUP,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    RESP,
    CS_GAP
`ifdef QSPINOR_CONT_READ_EN
    , HOLD
`endif
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [23:0] addr;
  logic [1:0]  len;
  logic [2:0]  cnt;      // address byte index, dummy slot index or data byte index
  logic [3:0]  gap_cnt;

  // Decoded controls from the next-state logic.
  logic        load;     // load new byte fields and trigger the engine next cycle
  logic [7:0]  ld_dout;
  logic [1:0]  ld_wid;
  logic        ld_dir;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        accept;
  logic        cap_data;
  logic        rsp_set;
  logic        csn_nxt;

`ifdef QSPINOR_CONT_READ_EN
  logic [23:0] next_addr;
  logic        pend;     // a non-contiguous request is latched and waits out CS_GAP
  logic        pend_set;
  logic        pend_clr;
`endif

`ifdef QSPINOR_CONT_READ_EN
  assign req_ready = (state == IDLE) || (state == HOLD);
`else
  assign req_ready = (state == IDLE);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ld_dout   = 8'h00;
    ld_wid    = 2'd2;
    ld_dir    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    accept    = 1'b0;
    cap_data  = 1'b0;
    rsp_set   = 1'b0;
`ifdef QSPINOR_CONT_READ_EN
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = CS_SETUP;
        end
      end
      CS_SETUP: begin
        load      = 1'b1;
        ld_dout   = READ_CMD;
        ld_wid    = 2'd0;
        ld_dir    = 1'b1;
        state_nxt = CMD;
      end
      CMD: begin
        if (io_done) begin
          load      = 1'b1;
          ld_dout   = addr[23:16];
          ld_dir    = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        // cnt is the index of the address byte currently in flight.
        if (io_done) begin
          load   = 1'b1;
          ld_dir = 1'b1;
          if (cnt == 3'd2) begin
            ld_dout   = MODE_BYTE;
            state_nxt = MODE;
          end else begin
            ld_dout = (cnt == 3'd0) ? addr[15:8] : addr[7:0];
            cnt_inc = 1'b1;
          end
        end
      end
      MODE: begin
        if (io_done) begin
          load      = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = DUMMY;
        end
      end
      DUMMY: begin
        // Dummy slots and data bytes share the same input-direction fields.
        if (io_done) begin
          load = 1'b1;
          if (cnt == DUMMY_LAST) begin
            cnt_clr   = 1'b1;
            state_nxt = DATA;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (io_done) begin
          cap_data = 1'b1;
          if (cnt == {1'b0, len}) begin
            rsp_set   = 1'b1;
            state_nxt = RESP;
          end else begin
            load    = 1'b1;
            cnt_inc = 1'b1;
          end
        end
      end
      RESP: begin
`ifdef QSPINOR_CONT_READ_EN
        state_nxt = HOLD;
`else
        state_nxt = CS_GAP;
`endif
      end
      CS_GAP: begin
        if (gap_cnt == GAP_LAST) begin
`ifdef QSPINOR_CONT_READ_EN
          if (pend) begin
            pend_clr  = 1'b1;
            state_nxt = CS_SETUP;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef QSPINOR_CONT_READ_EN
      HOLD: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_addr == next_addr) begin
            // Flash is still streaming from next_addr: continue with data.
            load      = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = DATA;
          end else begin
            pend_set  = 1'b1;
            state_nxt = CS_GAP;
          end
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Chip select is released only while idling or serving the inter-transaction gap.
  assign csn_nxt = (state_nxt == IDLE) || (state_nxt == CS_GAP);

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= 24'd0;
      len       <= 2'd0;
      cnt       <= 3'd0;
      gap_cnt   <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      io_trig   <= 1'b0;
      io_dout   <= 8'h00;
      io_dir    <= 1'b0;
      io_wid    <= 2'd0;
      spi_csn   <= 1'b1;
    end else begin
      io_trig <= load;
      if (load) begin
        io_dout <= ld_dout;
        io_wid  <= ld_wid;
        io_dir  <= ld_dir;
      end
      if (accept) begin
        addr     <= req_addr;
        len      <= req_len;
        rsp_data <= 32'd0;
      end
      if (cnt_clr) begin
        cnt <= 3'd0;
      end else if (cnt_inc) begin
        cnt <= cnt + 3'd1;
      end
      if (cap_data) begin
        rsp_data[{cnt[1:0], 3'b000} +: 8] <= io_din;
      end
      rsp_valid <= rsp_set;
      if (state == CS_GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end else begin
        gap_cnt <= 4'd0;
      end
      spi_csn <= csn_nxt;
    end
  end

`ifdef QSPINOR_CONT_READ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_addr <= 24'd0;
      pend      <= 1'b0;
    end else begin
      // Wraps modulo 2^24 like the flash's internal address counter.
      if (rsp_set) begin
        next_addr <= addr + 24'(len) + 24'd1;
      end
      if (pend_set) begin
        pend <= 1'b1;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qspinor_rd_seq.sv
`timescale 1ns/1ps
// tb_qspinor_rd_seq
// Bench for qspinor_rd_seq. A byte-engine model with random latency sits on
// the io_* side and behaves as a NOR flash: it decodes the byte stream on each
// chip-select-low session (command, address, mode, dummy) and returns data
// from a reference memory at an auto-incrementing address. Expected response
// words are pushed to a queue when a request is issued and popped when
// rsp_valid pulses.
module tb_qspinor_rd_seq;

  localparam int CS_IDLE = 2;
  localparam int DUMMY   = 2;

  // Clock / reset and DUT signals
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [1:0]  req_len;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        io_trig;
  logic        io_done;
  logic [7:0]  io_dout;
  logic [7:0]  io_din;
  logic        io_dir;
  logic [1:0]  io_wid;
  logic        spi_csn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  qspinor_rd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .io_trig   (io_trig),
    .io_done   (io_done),
    .io_dout   (io_dout),
    .io_din    (io_din),
    .io_dir    (io_dir),
    .io_wid    (io_wid),
    .spi_csn   (spi_csn)
  );

  // Scoreboard state
  int          errs = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ovr [int];
  int          push_cnt = 0;
  int          rsp_cnt = 0;
  int          trig_cnt = 0;
  int          rises = 0;
  int          high_run = 0;
  int          last_high_run = 0;
  int          sess = 0;
  logic        prev_csn = 1'b1;
  logic        prev_rv = 1'b0;
  logic        busy = 1'b0;
  int          left = 0;
  logic [7:0]  ret = 8'h00;
  logic [23:0] fa = 24'd0;
  logic [31:0] e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference flash contents: a few overridden bytes, otherwise an address hash.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (ovr.exists(int'(a))) return ovr[int'(a)];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hD5;
  endfunction

  function automatic logic [31:0] exp_rsp(input logic [23:0] a, input logic [1:0] l);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k <= int'(l); k++) r[8*k +: 8] = mem_byte(a + 24'(k));
    return r;
  endfunction

  // Response monitor, chip-select monitor and byte-engine/flash model.
  initial begin
    io_done = 1'b0;
    io_din  = 8'h00;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_cnt++;
        check("rsp_pulse", 32'(prev_rv), 32'd0);
        check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e);
        end
      end
      prev_rv = rsp_valid;

      if (spi_csn) begin
        if (!prev_csn) rises++;
        high_run++;
        sess = 0;
      end else begin
        if (prev_csn) last_high_run = high_run;
        high_run = 0;
      end
      prev_csn = spi_csn;

      io_done = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          if (left <= 1) begin
            io_done = 1'b1;
            io_din  = ret;
            busy    = 1'b0;
          end else begin
            left--;
          end
        end
        if (io_trig) begin
          check("trig_busy", 32'(busy), 32'd0);
          check("trig_csn", 32'(spi_csn), 32'd0);
          ret = 8'($urandom_range(0, 255));
          if (sess == 0) begin
            check("cmd", 32'({io_dout, io_wid, io_dir}), 32'({8'hEB, 2'd0, 1'b1}));
          end else if (sess <= 3) begin
            check("addr_fmt", 32'({io_wid, io_dir}), 32'({2'd2, 1'b1}));
            fa = {fa[15:0], io_dout};
          end else if (sess == 4) begin
            check("mode", 32'({io_dout, io_wid, io_dir}), 32'({8'h00, 2'd2, 1'b1}));
          end else if (sess <= 4 + DUMMY) begin
            check("dummy", 32'({io_dout, io_wid, io_dir}), 32'({8'h00, 2'd2, 1'b0}));
          end else begin
            check("data_fmt", 32'({io_wid, io_dir}), 32'({2'd2, 1'b0}));
            ret = mem_byte(fa);
            fa  = fa + 24'd1;
          end
          sess++;
          trig_cnt++;
          busy = 1'b1;
          left = $urandom_range(1, 3);
        end
      end
    end
  end

  // Driver tasks
  task automatic send_req(input logic [23:0] a, input logic [1:0] l);
    int n;
    n = 0;
    @(negedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    while (!req_ready && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("req_accept", 32'(n < 300), 32'd1);
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check("rsp_timeout", 32'(n < 400), 32'd1);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [1:0] l, input logic [31:0] x);
    exp_q.push_back(x);
    push_cnt++;
    send_req(a, l);
    wait_rsp();
  endtask

  // Main sequence
  initial begin
    int r0;
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 24'd0;
    req_len   = 2'd0;
    ovr[32'h400] = 8'h11;
    ovr[32'h401] = 8'h22;
    ovr[32'h402] = 8'h33;
    ovr[32'h403] = 8'h44;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_io_trig", 32'(io_trig), 32'd0);
    check("rst_io_dout", 32'(io_dout), 32'd0);
    check("rst_io_dir", 32'(io_dir), 32'd0);
    check("rst_io_wid", 32'(io_wid), 32'd0);
    check("rst_spi_csn", 32'(spi_csn), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1-byte read, flash byte at 0x123456 is 0xA5
    trig_cnt = 0;
    do_read(24'h123456, 2'd0, 32'h000000A5);
    check("t1_trigs", 32'(trig_cnt), 32'd8);

    // 4-byte read from overridden bytes
    trig_cnt = 0;
    r0 = rsp_cnt;
    do_read(24'h000400, 2'd3, 32'h44332211);
    check("t2_trigs", 32'(trig_cnt), 32'd11);
    check("t2_rsp_count", 32'(rsp_cnt - r0), 32'd1);
    check("t2_cs_gap", 32'(last_high_run >= CS_IDLE), 32'd1);

    // Two back-to-back contiguous reads
    trig_cnt = 0;
    do_read(24'h000100, 2'd3, exp_rsp(24'h000100, 2'd3));
    check("c1_trigs", 32'(trig_cnt), 32'd11);
    r0 = rises;
    trig_cnt = 0;
    do_read(24'h000104, 2'd3, exp_rsp(24'h000104, 2'd3));
`ifdef QSPINOR_CONT_READ_EN
    check("c2_trigs", 32'(trig_cnt), 32'd4);
    check("c2_csn_rises", 32'(rises - r0), 32'd0);
`else
    check("c2_trigs", 32'(trig_cnt), 32'd11);
    check("c2_csn_rises", 32'(rises - r0), 32'd1);
`endif

    // Non-contiguous read after that
    trig_cnt = 0;
    do_read(24'h000200, 2'd3, exp_rsp(24'h000200, 2'd3));
    check("n1_trigs", 32'(trig_cnt), 32'd11);
    check("n1_cs_gap", 32'(last_high_run >= CS_IDLE), 32'd1);

    // Contiguity across the 24-bit wrap
    trig_cnt = 0;
    do_read(24'hFFFFFE, 2'd3, exp_rsp(24'hFFFFFE, 2'd3));
    check("w1_trigs", 32'(trig_cnt), 32'd11);
    r0 = rises;
    trig_cnt = 0;
    do_read(24'h000002, 2'd3, exp_rsp(24'h000002, 2'd3));
`ifdef QSPINOR_CONT_READ_EN
    check("w2_trigs", 32'(trig_cnt), 32'd4);
    check("w2_csn_rises", 32'(rises - r0), 32'd0);
`else
    check("w2_trigs", 32'(trig_cnt), 32'd11);
    check("w2_csn_rises", 32'(rises - r0), 32'd1);
`endif

    // Asynchronous reset during the second address byte
    r0 = rsp_cnt;
    send_req(24'h00ABCD, 2'd1);
    n = 0;
    while (sess != 3 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_wait_addr", 32'(n < 200), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_spi_csn", 32'(spi_csn), 32'd1);
    check("arst_io_trig", 32'(io_trig), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk); #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("arst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    trig_cnt = 0;
    do_read(24'h000300, 2'd2, exp_rsp(24'h000300, 2'd2));
    check("post_rst_trigs", 32'(trig_cnt), 32'd10);

    repeat (10) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("rsp_total", 32'(rsp_cnt), 32'(push_cnt));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
